// File: rtl/step_clock_gen_if.sv
// Signal bundle between the step clock generator and its consumers.
// master = generator side, slave = board / CPU side.
interface step_clock_gen_if #(
  parameter int CNT_W = 16
);
  logic             btn_raw;
  logic             run_en;
  logic             step_clk;
  logic             step_pulse;
  logic             btn_level;
  logic [CNT_W-1:0] step_count;
  logic [1:0]       fsm_state;   // debug view of the pulse FSM

  modport master (
    input  btn_raw, run_en,
    output step_clk, step_pulse, btn_level, step_count, fsm_state
  );

  modport slave (
    output btn_raw, run_en,
    input  step_clk, step_pulse, btn_level, step_count, fsm_state
  );
endinterface

// File: rtl/step_clock_gen.sv
// Single-step clock generator: synchronises and debounces a push-button and
// emits one fixed-width clock pulse per press, or periodic pulses in auto-run.
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int PULSE_HIGH_CYCLES = 4,
  parameter int RUN_DIV           = 25000000,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  step_clock_gen_if.master bus
);

  localparam int DB_W  = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES)   : 1;
  localparam int DIV_W = (RUN_DIV           > 1) ? $clog2(RUN_DIV)           : 1;
  localparam int PH_W  = (PULSE_HIGH_CYCLES > 1) ? $clog2(PULSE_HIGH_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PULSE_HIGH_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic             sync1, sync2;
  logic [DB_W-1:0]  db_cnt;
  logic             btn_level_q, btn_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       state;
  logic [PH_W-1:0]  phase;
  logic             step_clk_q, step_pulse_q;
  logic [CNT_W-1:0] step_count_q;
  logic             man_req, auto_req, req;

  // Two-flop synchroniser on the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt      <= '0;
      btn_level_q <= 1'b0;
      btn_prev    <= 1'b0;
    end else begin
      btn_prev <= btn_level_q;
      if (sync2 != btn_level_q) begin
        if (db_cnt == DB_LAST) begin
          btn_level_q <= sync2;
          db_cnt      <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Divider is parked at zero in manual mode so the first tick is a full period away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!bus.run_en || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    man_req  = btn_level_q & ~btn_prev & ~bus.run_en;
    auto_req = bus.run_en & (div_cnt == DIV_LAST);
    req      = man_req | auto_req;
  end

  // Requests are only accepted in IDLE; anything arriving mid-pulse is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      phase        <= '0;
      step_clk_q   <= 1'b0;
      step_pulse_q <= 1'b0;
      step_count_q <= '0;
    end else begin
      step_pulse_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          step_clk_q <= 1'b0;
          if (req) begin
            state        <= ST_HIGH;
            phase        <= '0;
            step_clk_q   <= 1'b1;
            step_pulse_q <= 1'b1;
            step_count_q <= step_count_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (phase == PH_LAST) begin
            state      <= ST_LOW;
            phase      <= '0;
            step_clk_q <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_LOW: begin
          if (phase == PH_LAST) begin
            state <= ST_IDLE;
            phase <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          phase      <= '0;
          step_clk_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step_clk   = step_clk_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.btn_level  = btn_level_q;
  assign bus.step_count = step_count_q;
  assign bus.fsm_state  = state;

endmodule

// File: doc/step_clock_gen.md
Name: step_clock_gen

Overview:
- Generates the single-step clock `clk` that drives the pipelined CPU on the board.
- Sits upstream of the CPU top level. Runs from the 50 MHz board clock.
- Takes a raw push-button, synchronises and debounces it, and emits one clean, fixed-width clock pulse per press.
- Optional auto-run mode emits pulses at a fixed divided rate. Also provides a step counter for the display path.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles the synchronised button must differ from the debounced level before the level flips (20 ms at 50 MHz).
- PULSE_HIGH_CYCLES, 4, cycles `step_clk` stays high; the low guard phase has the same length.
- RUN_DIV, 25000000, auto-run tick period in cycles. Must be ≥ 2*PULSE_HIGH_CYCLES+1.
- CNT_W, 16, width of `step_count`.

Ports:
- clk  input  1  50 MHz board clock
- rst  input  1  asynchronous active-high reset
- btn_raw  input  1  raw, asynchronous, bouncing step button
- run_en  input  1  1 = auto-run from divider, 0 = manual button steps
- step_clk  output  1  clock to CPU; one high pulse per step
- step_pulse  output  1  one-cycle strobe, high in the first cycle of each step_clk high phase
- btn_level  output  1  debounced button level
- step_count  output  CNT_W  number of steps issued, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset: all flops cleared immediately.
  - step_clk=0, step_pulse=0, btn_level=0, step_count=0.
  - Sync flops=0, debounce counter=0, divider=0, FSM=IDLE.
- Synchroniser: two flops on `btn_raw`. The output `sync` lags `btn_raw` by 2 edges.
- Debounce:
  - If `sync` != `btn_level`, the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 on that edge, `btn_level` takes `sync` and the counter clears.
  - If `sync` == `btn_level`, the counter clears.
  - Any bounce back therefore restarts the count.
- Manual request: `btn_level` & ~`btn_prev` (`btn_prev` = `btn_level` delayed one cycle). Ignored when run_en=1.
- Auto request:
  - The divider counts while run_en=1. Request when divider == RUN_DIV-1; the divider wraps to 0 on that edge.
  - The divider is held at 0 while run_en=0, so the first auto tick comes RUN_DIV cycles after run_en rises.
- FSM (registered outputs):
  - IDLE: step_clk=0. On a request, go to HIGH: step_clk=1, step_pulse=1 for exactly that first cycle, step_count+1, phase counter=0.
  - HIGH: step_clk=1 for PULSE_HIGH_CYCLES cycles total, then go to LOW.
  - LOW: step_clk=0 for PULSE_HIGH_CYCLES cycles, then go to IDLE.
- Requests in HIGH/LOW are dropped, not queued. The minimum step period is 2*PULSE_HIGH_CYCLES+1 cycles.
- Latency: `btn_raw` rises and is held clean before edge 1. Then:
  - `btn_level`=1 after edge D+2.
  - `step_clk` rises at edge D+3.
- Release: a falling `btn_level` produces no step.
- run_en toggled mid-pulse: the current pulse completes unchanged. A mode change never truncates a pulse.
- step_count wraps 2^CNT_W-1 → 0 with no flag.
- Reset mid-HIGH: `step_clk` drops asynchronously. The CPU sees only a falling edge, which is acceptable.

Test Plan:
All scenarios use D=4, PULSE_HIGH_CYCLES=2, RUN_DIV=10, CNT_W=16.
- Reset: assert rst for 3 cycles with btn_raw=1 → every output stays 0 throughout; outputs are 0 immediately on rst assertion, with no clock edge needed.
- Clean press: btn_raw 0→1 before edge 1, held 20 cycles, then released → step_clk high on edges 7–8 only, step_pulse high at edge 7 only, step_count=1; the release gives no further pulse and the count stays 1.
- Bounce: btn_raw toggles every 2 cycles for 12 cycles, then settles at 0 → btn_level never rises, step_clk stays 0, step_count=0.
- Auto-run: run_en=1 for 50 cycles while btn_raw is pressed twice → exactly 5 step_clk pulses at period 10, step_count=5, button ignored; dropping run_en mid-HIGH still gives the full 2-cycle pulse.
- Reset mid-operation: assert rst during a HIGH phase → step_clk=0 at once, step_count=0; after release, a clean press behaves exactly as the clean-press scenario.
- Wrap: auto-run with RUN_DIV=5 for 65537 ticks → step_count goes 0xFFFF → 0x0000 → 0x0001 with no glitch on step_clk.
